vram_ctrl: RTL and testbench
============================

# vram_ctrl

Write-side controller for the 160x100, 8-bit-per-pixel (RGB332) frame buffer held inside the VGA controller. It shares that buffer's single write port between two requesters:
- the CPU, one byte per request;
- a built-in rectangle-fill engine that clears or paints regions without CPU involvement.

It runs in the CPU clock domain and drives the frame buffer's `cpu_wr` / `cpu_addr` / `cpu_data` write port directly.

## Interface

Parameters
- `FB_W`, 160, frame-buffer width in pixels
- `FB_H`, 100, frame-buffer height in pixels
- `FB_SIZE`, 16000, `FB_W*FB_H`; highest valid address is `FB_SIZE-1`

Ports (clock and reset: one clock, `cpu_clk`; reset `reset` is asynchronous and active-high)
- `cpu_clk` in 1, sole clock
- `reset` in 1, asynchronous, active-high
- `cpu_req` in 1, CPU write request; held until acked
- `cpu_addr` in 16, linear pixel address, `y*160+x`
- `cpu_data` in 8, pixel value
- `cpu_ack` out 1, combinational; high in the cycle the CPU request is granted
- `fill_start` in 1, one-cycle pulse that launches a fill
- `fill_x0` in 8, rectangle left column
- `fill_y0` in 7, rectangle top row
- `fill_w` in 8, rectangle width in pixels
- `fill_h` in 7, rectangle height in pixels
- `fill_color` in 8, fill pixel value
- `fill_busy` out 1, high from the cycle after an accepted `fill_start` until `fill_done`
- `fill_done` out 1, one-cycle pulse when a fill finishes
- `vmem_wr` out 1, registered write strobe to the frame buffer
- `vmem_addr` out 32, registered write address; upper bits are 0
- `vmem_data` out 8, registered write data

Reset values: `vmem_wr`=0, `vmem_addr`=0, `vmem_data`=0, `fill_busy`=0, `fill_done`=0, `cpu_ack`=0. The arbiter pointer resets to "fill last", so the CPU wins the first tie.

## Operation

**Fill FSM** has states IDLE, SETUP, RUN and DONE.
- **IDLE**
  - On `fill_start`, latch all `fill_*` inputs and go to SETUP.
  - `fill_start` in any other state is ignored.
- **SETUP** (1 cycle)
  - Clip the rectangle: `x1 = min(x0+w, 160)`, `y1 = min(y0+h, 100)`, computed at 9 bits.
  - Compute `row_base = y0*160` as `(y0<<7)+(y0<<5)`; no multiplier is used.
  - If `x0>=160`, `y0>=100`, `w==0` or `h==0`, go to DONE with no writes.
  - Otherwise set `x=x0`, `y=y0` and go to RUN.
- **RUN**
  - Requests a write of `row_base+x` every cycle.
  - On each grant, increment `x`.
  - When a write at `x==x1-1` is granted: set `x=x0`, `y=y+1`, `row_base+=160`.
  - When that write is also at `y==y1-1`, go to DONE.
- **DONE** (1 cycle)
  - Assert `fill_done`, then return to IDLE.

**Arbiter**
- Both requesters active: round-robin, granting whoever was not granted last.
- Single requester: granted in the same cycle.
- Exactly one grant per cycle, so the write port is never oversubscribed.

**Address handling**
- A CPU request with `cpu_addr >= FB_SIZE` is acked, but `vmem_wr` stays 0 (the request is dropped).
- Fill addresses are in range by construction.

## Timing

- A grant in cycle N produces `vmem_wr`=1 with the matching address and data in cycle N+1.
- `cpu_ack` is combinational from `cpu_req` and the fill state. The CPU may present a new request in the cycle after the ack.
- Under contention, CPU throughput is 1 write per 2 cycles, and so is fill throughput.
- A fill of `w×h` pixels with no CPU traffic:
  - `fill_start` in cycle 0;
  - `fill_busy` high from cycle 1;
  - writes in cycles 3 .. 2+w·h;
  - `fill_done` in cycle 2+w·h;
  - `fill_busy` low from cycle 3+w·h.
- Degenerate fill: `fill_done` in cycle 2.
- Asserting `reset` mid-fill aborts the fill:
  - FSM to IDLE, all outputs to reset values;
  - no `fill_done` is produced;
  - pixels already written remain.
- `fill_start` in the same cycle as `fill_done` is ignored.

## Structure

- Shared package `vram_pkg`:
  - `FB_W`, `FB_H`, `FB_SIZE`;
  - fill-state enum `{IDLE, SETUP, RUN, DONE}`;
  - grant encoding `{GNT_NONE, GNT_CPU, GNT_FILL}`.
- One sub-module, `vram_fill_engine`: the FSM, clipping and address generation. It exposes `req`, `addr` and `gnt` toward the arbiter, which stays in the top level.

## Test plan

- **Single CPU write:** `cpu_req` with addr 0x0A5, data 0xE0 → `cpu_ack` the same cycle; next cycle `vmem_wr`=1, addr 165, data 0xE0.
- **Out-of-range CPU write:** `cpu_req` with addr 16000 → acked, `vmem_wr` stays 0.
- **Basic fill:** x0=2, y0=3, w=3, h=2, color 0x1C → writes to 482, 483, 484, 642, 643, 644 in order; `fill_done` 6 cycles after the first write's grant cycle + 2 per Timing; `fill_busy` behaves as specified.
- **Clipped fill:** x0=158, y0=99, w=10, h=10 → exactly 2 writes, to 15998 and 15999, then `fill_done`. Separately, w=0 → `fill_done` in cycle 2 with no writes.
- **Contention:** continuous `cpu_req` during a 4-pixel fill → grants alternate CPU, FILL, CPU, ... (CPU first); `fill_done` after 4 fill writes; no cycle carries two grants.
- **Reset abort:** assert `reset` after 2 of 6 fill writes → `vmem_wr`, `fill_busy` and `fill_done` go to 0 immediately; after release, a new `fill_start` is accepted.

Source files
------------

// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared frame-buffer geometry and encodings for the write-side controller
package vram_pkg;

   localparam int FB_W    = 160;
   localparam int FB_H    = 100;
   localparam int FB_SIZE = FB_W * FB_H;

   typedef enum logic [1:0] {IDLE, SETUP, RUN, DONE} fill_state_t;

   typedef enum logic [1:0] {GNT_NONE, GNT_CPU, GNT_FILL} gnt_t;

endpackage

// File: rtl/vram_fill_engine.sv
// rtl/vram_fill_engine.sv - rectangle-fill FSM with clipping and linear address generation
module vram_fill_engine
   import vram_pkg::*;
(
   input  logic        cpu_clk,
   input  logic        reset,
   input  logic        fill_start,
   input  logic [7:0]  fill_x0,
   input  logic [6:0]  fill_y0,
   input  logic [7:0]  fill_w,
   input  logic [6:0]  fill_h,
   input  logic [7:0]  fill_color,
   input  logic        gnt,
   output logic        req,
   output logic [15:0] addr,
   output logic [7:0]  color,
   output logic        fill_busy,
   output logic        fill_done
);

   localparam logic [8:0]  W9      = 9'(FB_W);
   localparam logic [8:0]  H9      = 9'(FB_H);
   localparam logic [13:0] ROW_INC = 14'(FB_W);

   fill_state_t state;
   logic [7:0]  x0, w, x;
   logic [6:0]  y0, h, y;
   logic [8:0]  x1, y1;
   logic [13:0] row_base;
   logic [8:0]  x_end, y_end;
   logic        empty, last_col, last_row;

   assign x_end    = {1'b0, x0} + {1'b0, w};
   assign y_end    = {2'b0, y0} + {2'b0, h};
   assign empty    = ({1'b0, x0} >= W9) || ({2'b0, y0} >= H9) || (w == 8'd0) || (h == 7'd0);
   assign last_col = ({1'b0, x} == x1 - 9'd1);
   assign last_row = ({2'b0, y} == y1 - 9'd1);

   assign req  = (state == RUN);
   assign addr = {2'b0, row_base + {6'b0, x}};

   always_ff @(posedge cpu_clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         x0        <= '0;
         y0        <= '0;
         w         <= '0;
         h         <= '0;
         x         <= '0;
         y         <= '0;
         x1        <= '0;
         y1        <= '0;
         row_base  <= '0;
         color     <= '0;
         fill_busy <= 1'b0;
         fill_done <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (fill_start) begin
                  x0        <= fill_x0;
                  y0        <= fill_y0;
                  w         <= fill_w;
                  h         <= fill_h;
                  color     <= fill_color;
                  fill_busy <= 1'b1;
                  state     <= SETUP;
               end
            end
            SETUP: begin
               x1       <= (x_end > W9) ? W9 : x_end;
               y1       <= (y_end > H9) ? H9 : y_end;
               // y0*160 without a multiplier
               row_base <= ({7'b0, y0} << 7) + ({7'b0, y0} << 5);
               x        <= x0;
               y        <= y0;
               if (empty) begin
                  fill_done <= 1'b1;
                  state     <= DONE;
               end else begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (gnt) begin
                  if (last_col) begin
                     x        <= x0;
                     y        <= y + 7'd1;
                     row_base <= row_base + ROW_INC;
                     if (last_row) begin
                        fill_done <= 1'b1;
                        state     <= DONE;
                     end
                  end else begin
                     x <= x + 8'd1;
                  end
               end
            end
            DONE: begin
               fill_done <= 1'b0;
               fill_busy <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/vram_ctrl.sv
// rtl/vram_ctrl.sv - round-robin arbiter sharing the frame-buffer write port between CPU and fill engine
module vram_ctrl
   import vram_pkg::*;
(
   input  logic        cpu_clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_data,
   output logic        cpu_ack,
   input  logic        fill_start,
   input  logic [7:0]  fill_x0,
   input  logic [6:0]  fill_y0,
   input  logic [7:0]  fill_w,
   input  logic [6:0]  fill_h,
   input  logic [7:0]  fill_color,
   output logic        fill_busy,
   output logic        fill_done,
   output logic        vmem_wr,
   output logic [31:0] vmem_addr,
   output logic [7:0]  vmem_data
);

   localparam logic [15:0] ADDR_LIMIT = 16'(FB_SIZE);

   logic        fill_req;
   logic [15:0] fill_addr;
   logic [7:0]  fill_px;
   logic        last_fill;
   gnt_t        gnt;

   vram_fill_engine u_fill (
      .cpu_clk    (cpu_clk),
      .reset      (reset),
      .fill_start (fill_start),
      .fill_x0    (fill_x0),
      .fill_y0    (fill_y0),
      .fill_w     (fill_w),
      .fill_h     (fill_h),
      .fill_color (fill_color),
      .gnt        (gnt == GNT_FILL),
      .req        (fill_req),
      .addr       (fill_addr),
      .color      (fill_px),
      .fill_busy  (fill_busy),
      .fill_done  (fill_done)
   );

   // Under contention the requester that was not served last wins.
   always_comb begin
      gnt = GNT_NONE;
      if (!reset) begin
         if (cpu_req && fill_req) gnt = last_fill ? GNT_CPU : GNT_FILL;
         else if (cpu_req)        gnt = GNT_CPU;
         else if (fill_req)       gnt = GNT_FILL;
      end
   end

   assign cpu_ack = (gnt == GNT_CPU);

   always_ff @(posedge cpu_clk or posedge reset) begin
      if (reset) begin
         vmem_wr   <= 1'b0;
         vmem_addr <= '0;
         vmem_data <= '0;
         last_fill <= 1'b1;
      end else begin
         case (gnt)
            GNT_CPU: begin
               vmem_wr   <= (cpu_addr < ADDR_LIMIT);
               vmem_addr <= {16'b0, cpu_addr};
               vmem_data <= cpu_data;
               last_fill <= 1'b0;
            end
            GNT_FILL: begin
               vmem_wr   <= 1'b1;
               vmem_addr <= {16'b0, fill_addr};
               vmem_data <= fill_px;
               last_fill <= 1'b1;
            end
            default: vmem_wr <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_vram_ctrl.sv
// tb/tb_vram_ctrl.sv - self-checking bench for vram_ctrl
module tb_vram_ctrl;

   logic        cpu_clk = 1'b0;
   logic        reset;
   logic        cpu_req;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_data;
   logic        cpu_ack;
   logic        fill_start;
   logic [7:0]  fill_x0;
   logic [6:0]  fill_y0;
   logic [7:0]  fill_w;
   logic [6:0]  fill_h;
   logic [7:0]  fill_color;
   logic        fill_busy;
   logic        fill_done;
   logic        vmem_wr;
   logic [31:0] vmem_addr;
   logic [7:0]  vmem_data;

   int passed = 0;
   int total  = 0;
   bit m_last_fill;
   int ws, ds, as_n;

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  data;
      logic        exp_wr;
      int          exp_addr;
   } cpu_vec_t;

   cpu_vec_t vecs[7];

   vram_ctrl dut (
      .cpu_clk    (cpu_clk),
      .reset      (reset),
      .cpu_req    (cpu_req),
      .cpu_addr   (cpu_addr),
      .cpu_data   (cpu_data),
      .cpu_ack    (cpu_ack),
      .fill_start (fill_start),
      .fill_x0    (fill_x0),
      .fill_y0    (fill_y0),
      .fill_w     (fill_w),
      .fill_h     (fill_h),
      .fill_color (fill_color),
      .fill_busy  (fill_busy),
      .fill_done  (fill_done),
      .vmem_wr    (vmem_wr),
      .vmem_addr  (vmem_addr),
      .vmem_data  (vmem_data)
   );

   always #5 cpu_clk = ~cpu_clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input longint act, input longint exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic next_cycle();
      @(posedge cpu_clk);
      #1;
   endtask

   // Reference: the fill writes the clipped rectangle row by row; it asks for
   // the port from two cycles after the start until every pixel is granted,
   // and a contested cycle goes to whoever was not served last.
   task automatic do_fill(input int x0, input int y0, input int w, input int h,
                          input logic [7:0] color, input int cpu_pct, input int cpu_from,
                          output int writes_seen, output int done_seen, output int acks_seen);
      int fq[$];
      int fi = 0;
      int c = 0;
      int done_c;
      bit pv = 0;
      int pa = 0;
      int pd = 0;
      bit hold = 0;
      bit freq, eack, fgnt;
      for (int yy = y0; yy < y0 + h && yy < 100; yy++)
         for (int xx = x0; xx < x0 + w && xx < 160; xx++)
            fq.push_back(yy * 160 + xx);
      done_c = (fq.size() == 0) ? 2 : -1;
      writes_seen = 0;
      done_seen   = -1;
      acks_seen   = 0;
      fill_x0    = 8'(x0);
      fill_y0    = 7'(y0);
      fill_w     = 8'(w);
      fill_h     = 7'(h);
      fill_color = color;
      while (c < 600) begin
         fill_start = (c == 0);
         if (!hold) begin
            cpu_req  = (c >= cpu_from) && (done_c < 0 || c <= done_c) &&
                       ($urandom_range(1, 100) <= cpu_pct);
            cpu_addr = 16'($urandom_range(0, 16100));
            cpu_data = 8'($urandom);
         end
         if (fq.size() > 0 && fi == fq.size() && done_c < 0) done_c = c;
         freq = (c >= 2) && (fi < fq.size());
         eack = cpu_req && (!freq || m_last_fill);
         fgnt = freq && !eack;
         #2;
         check("cpu_ack", cpu_ack, eack);
         check("vmem_wr", vmem_wr, pv);
         if (pv) begin
            check("vmem_addr", vmem_addr, pa);
            check("vmem_data", vmem_data, pd);
         end
         check("fill_done", fill_done, c == done_c);
         check("fill_busy", fill_busy, c >= 1 && (done_c < 0 || c <= done_c));
         if (vmem_wr) writes_seen++;
         if (cpu_ack) acks_seen++;
         if (fill_done && done_seen < 0) done_seen = c;
         if (eack) begin
            pv = (cpu_addr < 16000);
            pa = cpu_addr;
            pd = cpu_data;
            m_last_fill = 0;
         end else if (fgnt) begin
            pv = 1;
            pa = fq[fi];
            pd = color;
            fi++;
            m_last_fill = 1;
         end else begin
            pv = 0;
         end
         hold = cpu_req && !eack;
         next_cycle();
         fill_start = 1'b0;
         c++;
         if (done_c >= 0 && c > done_c + 1) break;
      end
      cpu_req = 1'b0;
      check("fill_terminated", c < 600, 1);
   endtask

   initial begin
      vecs[0] = '{16'h00A5, 8'hE0, 1'b1, 165};
      vecs[1] = '{16'd0,    8'h01, 1'b1, 0};
      vecs[2] = '{16'd15999, 8'hFF, 1'b1, 15999};
      vecs[3] = '{16'd16000, 8'h55, 1'b0, 0};
      vecs[4] = '{16'hFFFF, 8'h12, 1'b0, 0};
      vecs[5] = '{16'd159,  8'h3C, 1'b1, 159};
      vecs[6] = '{16'd160,  8'h81, 1'b1, 160};

      reset      = 1'b1;
      cpu_req    = 1'b1;
      cpu_addr   = 16'd5;
      cpu_data   = 8'hAA;
      fill_start = 1'b0;
      fill_x0    = '0;
      fill_y0    = '0;
      fill_w     = '0;
      fill_h     = '0;
      fill_color = '0;
      m_last_fill = 1;
      next_cycle();
      next_cycle();
      #2;
      check("rst_cpu_ack", cpu_ack, 0);
      check("rst_vmem_wr", vmem_wr, 0);
      check("rst_vmem_addr", vmem_addr, 0);
      check("rst_vmem_data", vmem_data, 0);
      check("rst_fill_busy", fill_busy, 0);
      check("rst_fill_done", fill_done, 0);
      next_cycle();
      reset   = 1'b0;
      cpu_req = 1'b0;
      next_cycle();

      for (int i = 0; i < 7; i++) begin
         cpu_req  = 1'b1;
         cpu_addr = vecs[i].addr;
         cpu_data = vecs[i].data;
         #2;
         check("vec_cpu_ack", cpu_ack, 1);
         next_cycle();
         cpu_req = 1'b0;
         m_last_fill = 0;
         #2;
         check("vec_vmem_wr", vmem_wr, vecs[i].exp_wr);
         if (vecs[i].exp_wr) begin
            check("vec_vmem_addr", vmem_addr, vecs[i].exp_addr);
            check("vec_vmem_data", vmem_data, vecs[i].data);
         end
         next_cycle();
      end

      do_fill(2, 3, 3, 2, 8'h1C, 0, 0, ws, ds, as_n);
      check("basic_writes", ws, 6);
      check("basic_done_cycle", ds, 8);

      do_fill(158, 99, 10, 10, 8'hE3, 0, 0, ws, ds, as_n);
      check("clip_writes", ws, 2);
      check("clip_done_cycle", ds, 4);

      do_fill(5, 5, 0, 4, 8'h11, 0, 0, ws, ds, as_n);
      check("degen_writes", ws, 0);
      check("degen_done_cycle", ds, 2);

      do_fill(10, 5, 4, 1, 8'h42, 100, 2, ws, ds, as_n);
      check("contend_done_cycle", ds, 10);
      check("contend_cpu_acks", as_n, 5);

      // Reset in the middle of a 6-pixel fill, after two writes.
      fill_x0 = 8'd0; fill_y0 = 7'd0; fill_w = 8'd3; fill_h = 7'd2; fill_color = 8'h5A;
      fill_start = 1'b1;
      next_cycle();
      fill_start = 1'b0;
      repeat (3) next_cycle();
      #2;
      check("abort_pre_wr", vmem_wr, 1);
      check("abort_pre_addr", vmem_addr, 1);
      next_cycle();
      reset = 1'b1;
      #1;
      check("abort_vmem_wr", vmem_wr, 0);
      check("abort_fill_busy", fill_busy, 0);
      check("abort_fill_done", fill_done, 0);
      check("abort_vmem_addr", vmem_addr, 0);
      next_cycle();
      reset = 1'b0;
      m_last_fill = 1;
      for (int i = 0; i < 8; i++) begin
         #2;
         check("abort_no_done", fill_done, 0);
         check("abort_no_wr", vmem_wr, 0);
         next_cycle();
      end
      do_fill(20, 40, 2, 2, 8'h77, 0, 0, ws, ds, as_n);
      check("restart_writes", ws, 4);
      check("restart_done_cycle", ds, 6);

      for (int i = 0; i < 12; i++) begin
         do_fill(int'($urandom_range(0, 170)), int'($urandom_range(0, 110)),
                 int'($urandom_range(0, 12)), int'($urandom_range(0, 5)),
                 8'($urandom), int'($urandom_range(0, 80)), 0, ws, ds, as_n);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
